ws_sequencer: RTL and testbench

Instruction sequencer for the weight-stationary `core`. It generates the 40-bit `inst` word that runs a full 3x3 convolution pass. For each kernel position kij it loads `col` weight rows from XMEM into the array, streams `len_nij` activation rows, then issues the end-of-kij marker. In parallel it drains OFIFO into PMEM, so the hand-written load/execute sequencing is replaced by hardware behind a start/done handshake.

---
 rtl/ws_sequencer.sv | 152 +++++++++++++++
 tb/tb_ws_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_sequencer.sv
// Weight-stationary instruction sequencer: generates the core instruction word
// for a full convolution pass (weight load, activation stream, kij marker, PSUM drain).
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading col weight rows for the current kij from XMEM
// EXEC   | streaming len_nij activation rows
// MARK   | one-cycle end-of-kij marker (load/execute/mode all set)
// DRAIN  | waiting for PMEM writes to catch up with this kij
// DONE   | one-cycle done pulse
module ws_sequencer #(
    parameter int         COL     = 8,
    parameter int         LEN_KIJ = 9,
    parameter int         LEN_NIJ = 36,
    parameter logic [7:0] W_BASE  = 8'h80,
    parameter logic [7:0] X_BASE  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        l0_ready,
    input  logic        ofifo_valid,
    output logic [39:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int P_TOTAL = LEN_KIJ * LEN_NIJ;

    typedef enum logic [2:0] {IDLE, LOAD_W, EXEC, MARK, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  kij;
    logic [5:0]  r;
    logic [8:0]  p;
    logic [8:0]  p_nxt;
    logic [8:0]  a_pmem_q;
    logic [8:0]  drain_target;
    logic        active;
    logic        issue;
    logic        pmem_wr;
    logic        last_row;
    logic        kij_last;
    logic        drain_met;
    logic        l0_wr_q;
    logic        l0_rd_q;
    logic [2:0]  tag;
    logic [2:0]  tag_d1, tag_d2, tag_d3;
    logic [7:0]  a0;

    always_comb begin
        active       = (state == LOAD_W) || (state == EXEC) ||
                       (state == MARK)   || (state == DRAIN);
        issue        = ((state == LOAD_W) || (state == EXEC)) && l0_ready;
        pmem_wr      = active && ofifo_valid && (p < 9'(P_TOTAL));
        p_nxt        = p + 9'(pmem_wr);
        drain_target = 9'((int'(kij) + 1) * LEN_NIJ);
        // Count this cycle's write so done follows the final write by one cycle.
        drain_met    = (p_nxt >= drain_target);
        kij_last     = (kij == 4'(LEN_KIJ - 1));
        last_row     = (state == LOAD_W) ? (r == 6'(COL - 1)) : (r == 6'(LEN_NIJ - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_W;
            LOAD_W:  if (issue && last_row) state_nxt = EXEC;
            EXEC:    if (issue && last_row) state_nxt = MARK;
            MARK:    state_nxt = DRAIN;
            DRAIN:   if (drain_met) state_nxt = kij_last ? DONE : LOAD_W;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = active;
        done = (state == DONE);
        a0   = 8'h00;
        tag  = 3'b000;
        case (state)
            LOAD_W: begin
                if (issue) begin
                    a0  = W_BASE + 8'(int'(kij) * COL) + 8'(r);
                    tag = 3'b001;
                end
            end
            EXEC: begin
                if (issue) begin
                    a0  = X_BASE + 8'(r);
                    tag = 3'b010;
                end
            end
            MARK:    tag = 3'b111;
            default: ;
        endcase
        inst = {active, 1'b0, ~pmem_wr, ~pmem_wr, (pmem_wr ? p : a_pmem_q),
                1'b1, 8'h00, ~issue, 1'b1, a0,
                pmem_wr, 2'b00, l0_rd_q, l0_wr_q, tag_d3};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kij      <= '0;
            r        <= '0;
            p        <= '0;
            a_pmem_q <= '0;
            l0_wr_q  <= 1'b0;
            l0_rd_q  <= 1'b0;
            tag_d1   <= '0;
            tag_d2   <= '0;
            tag_d3   <= '0;
        end else begin
            // Control pipeline shifts in every state so trailing tags drain out.
            l0_wr_q <= issue;
            l0_rd_q <= l0_wr_q;
            tag_d1  <= tag;
            tag_d2  <= tag_d1;
            tag_d3  <= tag_d2;
            if (pmem_wr) begin
                p        <= p_nxt;
                a_pmem_q <= p;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        kij <= '0;
                        r   <= '0;
                        p   <= '0;
                    end
                end
                LOAD_W, EXEC: begin
                    if (issue) r <= last_row ? 6'd0 : r + 6'd1;
                end
                DRAIN: begin
                    if (drain_met && !kij_last) kij <= kij + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_sequencer.sv
// Self-checking bench for ws_sequencer: directed vector table plus full passes
// checked cycle-by-cycle against a queue-based reference model.
module tb_ws_sequencer;

    localparam int COL   = 8;
    localparam int LK    = 9;
    localparam int LN    = 36;
    localparam int TOTAL = LK * LN;
    localparam int M_IDLE = 0, M_ISS = 1, M_MARK = 2, M_DRAIN = 3, M_DONE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        l0_ready = 1'b0;
    logic        ofifo_valid = 1'b0;
    logic [39:0] inst;
    logic        busy;
    logic        done;

    ws_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .l0_ready(l0_ready),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst, st, l0, ov;
        logic       e_cen0;
        logic [7:0] e_a0;
        logic       e_l0wr, e_l0rd;
        logic [2:0] e_tag;
        logic       e_busy, e_rd;
        logic [8:0] e_ap;
    } vec_t;
    vec_t vt[18];

    // reference model state
    bit          model_en = 0;
    int          ph, m_kij, in_kij, writes, cyc, rnd_mode, last_push;
    logic [8:0]  last_a;
    logic [10:0] iss_q[$];
    int          rdy_q[$];
    logic [2:0]  tag_h1, tag_h2, tag_h3;
    logic        iss_h1, iss_h2;
    int          rd_cnt, mark_cnt;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic build_queue();
        iss_q.delete();
        for (int k = 0; k < LK; k++) begin
            for (int i = 0; i < COL; i++) iss_q.push_back({3'b001, 8'(8'h80 + k * COL + i)});
            for (int i = 0; i < LN; i++)  iss_q.push_back({3'b010, 8'(i)});
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE; m_kij = 0; in_kij = 0; writes = 0; last_a = '0;
        tag_h1 = '0; tag_h2 = '0; tag_h3 = '0; iss_h1 = 1'b0; iss_h2 = 1'b0;
        iss_q.delete(); rdy_q.delete(); last_push = 0;
    endtask

    task automatic model_cycle();
        logic        e_busy, e_done, e_iss, e_wr;
        logic [7:0]  e_a0;
        logic [2:0]  cur_tag;
        logic [8:0]  e_ap;
        logic [39:0] exp_w, mask;
        int          t;
        e_busy  = (ph == M_ISS) || (ph == M_MARK) || (ph == M_DRAIN);
        e_done  = (ph == M_DONE);
        e_iss   = (ph == M_ISS) && l0_ready && (iss_q.size() > 0);
        e_a0    = e_iss ? iss_q[0][7:0] : 8'h00;
        cur_tag = e_iss ? iss_q[0][10:8] : ((ph == M_MARK) ? 3'b111 : 3'b000);
        e_wr    = e_busy && ofifo_valid && (writes < TOTAL);
        e_ap    = e_wr ? 9'(writes) : last_a;
        exp_w   = {e_busy, 1'b0, ~e_wr, ~e_wr, e_ap, 1'b1, 8'h00, ~e_iss, 1'b1, e_a0,
                   e_wr, 2'b00, iss_h2, iss_h1, tag_h3};
        mask    = e_iss ? '1 : ~(40'hFF << 8);
        chk("inst", inst & mask, exp_w & mask);
        chk("busy", 40'(busy), 40'(e_busy));
        chk("done", 40'(done), 40'(e_done));
        if (inst[7]) rd_cnt++;
        if (inst[2:0] == 3'b111) mark_cnt++;

        if (e_iss) begin
            if (iss_q[0][10:8] == 3'b010) begin
                t = cyc + 6 + ((rnd_mode == 1) ? int'($urandom_range(0, 4)) : 0);
                if (t < last_push) t = last_push;
                rdy_q.push_back(t);
                last_push = t;
            end
            void'(iss_q.pop_front());
            in_kij++;
        end
        if (e_wr) begin
            writes++;
            last_a = e_ap;
            if (rdy_q.size() > 0) void'(rdy_q.pop_front());
        end
        case (ph)
            M_ISS:   if (in_kij == COL + LN) ph = M_MARK;
            M_MARK:  ph = M_DRAIN;
            M_DRAIN: begin
                if (writes >= (m_kij + 1) * LN) begin
                    if (m_kij == LK - 1) ph = M_DONE;
                    else begin m_kij++; in_kij = 0; ph = M_ISS; end
                end
            end
            M_DONE:  ph = M_IDLE;
            default: begin
                if (start) begin
                    ph = M_ISS; m_kij = 0; in_kij = 0; writes = 0;
                    build_queue();
                end
            end
        endcase
        tag_h3 = tag_h2; tag_h2 = tag_h1; tag_h1 = cur_tag;
        iss_h2 = iss_h1; iss_h1 = e_iss;
        if (reset) model_reset();
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_en) model_cycle();
        @(posedge clk);
        #1;
    endtask

    // rnd: 0 = l0_ready held high, 1 = randomized, 2 = 3-cycle stall in EXEC at r=10
    task automatic run_pass(input int rnd, input int rst_kij);
        int n;
        int stall_cnt;
        bit stalled, finished, aborted;
        rnd_mode = rnd; rd_cnt = 0; mark_cnt = 0;
        stall_cnt = 0; stalled = 0; finished = 0; aborted = 0; n = 0;
        reset = 1'b0; start = 1'b1; l0_ready = 1'b1; ofifo_valid = 1'b0;
        tick();
        start = 1'b0;
        while (!finished && n < 6000) begin
            if (rnd == 2 && !stalled && ph == M_ISS && m_kij == 0 && in_kij == COL + 10) begin
                stalled = 1; stall_cnt = 3;
            end
            if (rnd == 1) l0_ready = ($urandom_range(0, 3) != 0);
            else          l0_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            ofifo_valid = ((rdy_q.size() > 0) && (rdy_q[0] <= cyc) &&
                           ((rnd != 1) || ($urandom_range(0, 2) != 0))) || (writes >= TOTAL);
            start = (rnd == 1) && ($urandom_range(0, 15) == 0);
            reset = (rst_kij >= 0) && (ph == M_ISS) && (m_kij == rst_kij) && (in_kij == COL + 10);
            aborted  = reset;
            finished = reset || (ph == M_DONE);
            tick();
            n++;
        end
        if (!finished) begin
            tests++; fails++;
            $display("FAIL pass_timeout mode=%0d actual=%0d cycles required=done", rnd, n);
            reset = 1'b1;
            tick();
        end
        reset = 1'b0; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b1;
        repeat (3) tick();
        ofifo_valid = 1'b0;
        if (finished && !aborted) begin
            chk("pmem_write_count", 40'(rd_cnt), 40'(TOTAL));
            chk("mark_tag_count", 40'(mark_cnt), 40'(LK));
        end
    endtask

    initial begin
        vt[0]  = '{0,1,1,0, 1,8'h00, 0,0,3'd0, 0,0,9'd0};
        vt[1]  = '{0,0,1,0, 0,8'h80, 0,0,3'd0, 1,0,9'd0};
        vt[2]  = '{0,0,1,0, 0,8'h81, 1,0,3'd0, 1,0,9'd0};
        vt[3]  = '{0,0,0,0, 1,8'h00, 1,1,3'd0, 1,0,9'd0};
        vt[4]  = '{0,0,1,0, 0,8'h82, 0,1,3'd1, 1,0,9'd0};
        vt[5]  = '{0,0,1,0, 0,8'h83, 1,0,3'd1, 1,0,9'd0};
        vt[6]  = '{0,0,1,0, 0,8'h84, 1,1,3'd0, 1,0,9'd0};
        vt[7]  = '{0,0,1,0, 0,8'h85, 1,1,3'd1, 1,0,9'd0};
        vt[8]  = '{0,0,1,0, 0,8'h86, 1,1,3'd1, 1,0,9'd0};
        vt[9]  = '{0,0,1,0, 0,8'h87, 1,1,3'd1, 1,0,9'd0};
        vt[10] = '{0,0,1,0, 0,8'h00, 1,1,3'd1, 1,0,9'd0};
        vt[11] = '{0,0,1,0, 0,8'h01, 1,1,3'd1, 1,0,9'd0};
        vt[12] = '{0,0,1,1, 0,8'h02, 1,1,3'd1, 1,1,9'd0};
        vt[13] = '{0,0,1,1, 0,8'h03, 1,1,3'd2, 1,1,9'd1};
        vt[14] = '{0,0,1,0, 0,8'h04, 1,1,3'd2, 1,0,9'd1};
        vt[15] = '{0,1,1,0, 0,8'h05, 1,1,3'd2, 1,0,9'd1};
        vt[16] = '{1,0,1,0, 0,8'h06, 1,1,3'd2, 1,0,9'd1};
        vt[17] = '{0,0,1,0, 1,8'h00, 0,0,3'd0, 0,0,9'd0};

        cyc = 0;
        model_reset();
        reset = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("reset_inst", inst, 40'h30_0403_0000);
        chk("reset_busy", 40'(busy), 40'd0);
        chk("reset_done", 40'(done), 40'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            logic [39:0] exp_w, mask;
            reset = vt[i].rst; start = vt[i].st; l0_ready = vt[i].l0; ofifo_valid = vt[i].ov;
            @(negedge clk);
            exp_w = {vt[i].e_busy, 1'b0, ~vt[i].e_rd, ~vt[i].e_rd, vt[i].e_ap, 1'b1, 8'h00,
                     vt[i].e_cen0, 1'b1, vt[i].e_a0, vt[i].e_rd, 2'b00,
                     vt[i].e_l0rd, vt[i].e_l0wr, vt[i].e_tag};
            mask  = vt[i].e_cen0 ? ~(40'hFF << 8) : '1;
            chk($sformatf("vec%0d_inst", i), inst & mask, exp_w & mask);
            chk($sformatf("vec%0d_busy", i), 40'(busy), 40'(vt[i].e_busy));
            chk($sformatf("vec%0d_done", i), 40'(done), 40'd0);
            @(posedge clk);
            #1;
        end

        reset = 1'b0; start = 1'b0;
        model_reset();
        model_en = 1;
        run_pass(0, -1);
        run_pass(2, -1);
        run_pass(0, 4);
        run_pass(0, -1);
        run_pass(1, -1);
        run_pass(1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
